// File: rtl/spram_pkg.sv
// Shared constants and encodings for the SPRAM arbiter slice.
package spram_pkg;

  localparam int SPRAM_AW    = 14;
  localparam int SPRAM_DW    = 16;
  localparam int SPRAM_MW    = 4;
  localparam int SPRAM_DEPTH = 1 << SPRAM_AW;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/spram_core.sv
// Thin wrapper around the iCE40 SB_SPRAM256KA; simulation builds use an
// equivalent behavioural array with synchronous read and nibble write masks.
module spram_core
  import spram_pkg::*;
(
  input  logic                clk,
  input  logic                cs,
  input  logic                we,
  input  logic [SPRAM_AW-1:0] addr,
  input  logic [SPRAM_DW-1:0] wdata,
  input  logic [SPRAM_MW-1:0] mask,
  input  logic                standby,
  output logic [SPRAM_DW-1:0] rdata
);

`ifdef SYNTHESIS
  SB_SPRAM256KA u_spram (
    .ADDRESS    (addr),
    .DATAIN     (wdata),
    .MASKWREN   (mask),
    .WREN       (we),
    .CHIPSELECT (cs),
    .CLOCK      (clk),
    .STANDBY    (standby),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata)
  );
`else
  logic [SPRAM_DW-1:0] mem_q [SPRAM_DEPTH];
  logic [SPRAM_DW-1:0] rdata_q;

  // Each MASKWREN bit enables one 4-bit nibble of the word.
  always_ff @(posedge clk) begin
    if (cs && !standby) begin
      if (we) begin
        for (int i = 0; i < SPRAM_MW; i++) begin
          if (mask[i]) mem_q[addr][4*i +: 4] <= wdata[4*i +: 4];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin two-port arbiter in front of a single SPRAM, with idle-driven
// standby and a fixed wake delay before the first grant.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int IDLE_CYCLES = 256,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [SPRAM_AW-1:0] a_addr,
  input  logic [SPRAM_DW-1:0] a_wdata,
  input  logic [SPRAM_MW-1:0] a_mask,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [SPRAM_DW-1:0] a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [SPRAM_AW-1:0] b_addr,
  input  logic [SPRAM_DW-1:0] b_wdata,
  input  logic [SPRAM_MW-1:0] b_mask,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [SPRAM_DW-1:0] b_rdata,
  output logic                standby
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  port_e               last_gnt_q, last_gnt_d;
  logic                pend_q, pend_d;
  port_e               pend_port_q, pend_port_d;

  logic                any_req;
  logic                issue;
  logic                sel_b;
  logic                cs;
  logic                we;
  logic [SPRAM_AW-1:0] addr;
  logic [SPRAM_DW-1:0] wdata;
  logic [SPRAM_MW-1:0] mask;
  logic [SPRAM_DW-1:0] core_rdata;

  assign any_req = a_req | b_req;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    last_gnt_d = last_gnt_q;
    issue      = 1'b0;
    sel_b      = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (any_req) begin
          // B wins only when alone or when A was served last.
          issue      = 1'b1;
          sel_b      = b_req & (~a_req | (last_gnt_q == PORT_A));
          last_gnt_d = sel_b ? PORT_B : PORT_A;
          idle_cnt_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = ST_STANDBY;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_STANDBY: begin
        if (any_req) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // No access is launched while reset is held, so nothing survives it.
  assign a_gnt = issue & ~sel_b & ~rst;
  assign b_gnt = issue &  sel_b & ~rst;

  assign cs    = a_gnt | b_gnt;
  assign we    = sel_b ? b_we    : a_we;
  assign addr  = sel_b ? b_addr  : a_addr;
  assign wdata = sel_b ? b_wdata : a_wdata;
  assign mask  = sel_b ? b_mask  : a_mask;

  assign pend_d      = cs & ~we;
  assign pend_port_d = sel_b ? PORT_B : PORT_A;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      last_gnt_q <= PORT_B;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      last_gnt_q <= last_gnt_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_port_q <= pend_port_d;
  end

  spram_core u_core (
    .clk     (clk),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .mask    (mask),
    .standby (standby),
    .rdata   (core_rdata)
  );

  // Read data is routed by the registered tag, not by this clk's grant.
  assign a_rvalid = pend_q & (pend_port_q == PORT_A) & ~rst;
  assign b_rvalid = pend_q & (pend_port_q == PORT_B) & ~rst;
  assign a_rdata  = a_rvalid ? core_rdata : '0;
  assign b_rdata  = b_rvalid ? core_rdata : '0;
  assign standby  = (state_q == ST_STANDBY);

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: directed scenarios plus randomized traffic against
// a cycle-level reference model of the arbitration and power rules.
module tb_spram_arbiter;

  localparam int IDLE = 8;
  localparam int WAKE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [13:0] a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic [3:0]  a_mask = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [13:0] b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic [3:0]  b_mask = '0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, standby;
  logic [15:0] a_rdata, b_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .standby(standby)
  );

  // {a_gnt, b_gnt, a_rvalid, b_rvalid, standby, a_rdata, b_rdata}
  logic [36:0] obs, exp_v;

  // Reference model: power mode 0=running 1=asleep 2=waking.
  int          m_mode, m_idle, m_wake;
  bit          m_last_b, m_pend, m_pend_b;
  logic [15:0] m_pend_data;
  logic [15:0] m_mem [0:16383];

  function automatic void model_reset();
    m_mode = 0; m_idle = 0; m_wake = 0;
    m_last_b = 1'b1; m_pend = 1'b0; m_pend_b = 1'b0;
  endfunction

  function automatic logic [36:0] model_step();
    logic ag = 1'b0, bg = 1'b0, arv = 1'b0, brv = 1'b0, sb;
    logic [15:0] ard = '0, brd = '0;
    bit pick_b;
    logic we; logic [13:0] ad; logic [15:0] wd; logic [3:0] mk;
    sb = (m_mode == 1);
    if (m_pend) begin
      if (m_pend_b) begin brv = 1'b1; brd = m_pend_data; end
      else begin arv = 1'b1; ard = m_pend_data; end
    end
    m_pend = 1'b0;
    if (m_mode == 0) begin
      if (a_req || b_req) begin
        pick_b = b_req && (!a_req || !m_last_b);
        m_last_b = pick_b;
        m_idle = 0;
        ag = !pick_b; bg = pick_b;
        we = pick_b ? b_we : a_we;
        ad = pick_b ? b_addr : a_addr;
        wd = pick_b ? b_wdata : a_wdata;
        mk = pick_b ? b_mask : a_mask;
        if (we) begin
          for (int i = 0; i < 4; i++) if (mk[i]) m_mem[ad][4*i +: 4] = wd[4*i +: 4];
        end else begin
          m_pend = 1'b1; m_pend_b = pick_b; m_pend_data = m_mem[ad];
        end
      end else begin
        m_idle++;
        if (m_idle == IDLE) begin m_mode = 1; m_idle = 0; end
      end
    end else if (m_mode == 1) begin
      if (a_req || b_req) begin m_mode = 2; m_wake = 0; end
    end else begin
      m_wake++;
      if (m_wake == WAKE) m_mode = 0;
    end
    return {ag, bg, arv, brv, sb, ard, brd};
  endfunction

  task automatic sample_step();
    @(negedge clk);
    exp_v = model_step();
    obs = {a_gnt, b_gnt, a_rvalid, b_rvalid, standby, a_rdata, b_rdata};
  endtask

  // Requesters drop their request once they have seen the grant.
  task automatic advance();
    @(posedge clk); #1;
    if (obs[36]) a_req = 1'b0;
    if (obs[35]) b_req = 1'b0;
  endtask

  task automatic test_reset();
    a_req = 1'b1; b_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {a_gnt, b_gnt, a_rvalid, b_rvalid, standby, a_rdata, b_rdata};
    checks++;
    if (obs !== 37'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, 37'd0); end
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    model_reset();
    sample_step(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_reset got=%h exp=%h", obs, exp_v); end
    advance();
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0010; a_wdata = 16'hBEEF; a_mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL wr_rd_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      checks++;
      if (i < 2 && !(a_gnt === 1'b1 && b_gnt === 1'b0 && a_rvalid === 1'b0))
        begin errors++; $display("FAIL wr_rd_gnt cyc=%0d got=%b%b%b exp=100", i, a_gnt, b_gnt, a_rvalid); end
      if (i == 2 && !(a_rvalid === 1'b1 && a_rdata === 16'hBEEF && b_rvalid === 1'b0 && b_rdata === 16'h0))
        begin errors++; $display("FAIL wr_rd_data got=%b %h exp=1 beef", a_rvalid, a_rdata); end
      advance();
      if (i == 0) begin a_req = 1'b1; a_we = 1'b0; end
    end
  endtask

  task automatic test_contention();
    logic pa = 1'b0, pb = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0010;
    for (int i = 0; i < 9; i++) begin
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i < 8) begin
        checks++;
        if ((a_gnt ^ b_gnt) !== 1'b1 || (i > 0 && a_gnt === pa))
          begin errors++; $display("FAIL rr_alternate cyc=%0d got=%b%b prev_a=%b", i, a_gnt, b_gnt, pa); end
      end
      if (i > 0) begin
        checks++;
        if (a_rvalid !== pa || b_rvalid !== pb)
          begin errors++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp=%b%b", i, a_rvalid, b_rvalid, pa, pb); end
      end
      pa = a_gnt; pb = b_gnt;
      advance();
      if (i < 7) begin a_req = 1'b1; b_req = 1'b1; end
      else begin a_req = 1'b0; b_req = 1'b0; end
    end
  endtask

  task automatic test_mask_top();
    a_req = 1'b1; a_we = 1'b1; a_addr = 14'h3FFF; a_wdata = 16'hFFFF; a_mask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mask_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 3) begin
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'hFF00)
          begin errors++; $display("FAIL mask_data got=%b %h exp=1 ff00", a_rvalid, a_rdata); end
      end
      advance();
      if (i == 0) begin a_req = 1'b1; a_wdata = 16'h0000; a_mask = 4'b0011; end
      if (i == 1) begin a_req = 1'b1; a_we = 1'b0; end
    end
  endtask

  task automatic test_standby_wake();
    a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0020; a_wdata = 16'h1234; a_mask = 4'hF;
    sample_step(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_write got=%h exp=%h", obs, exp_v); end
    advance();
    for (int k = 0; k < 9; k++) begin
      sample_step(); checks++;
      if (obs !== exp_v || standby !== (k == 8))
        begin errors++; $display("FAIL idle_standby k=%0d got=%h exp=%h", k, obs, exp_v); end
      advance();
    end
    b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0010;
    for (int s = 0; s < 5; s++) begin
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL wake_model s=%0d got=%h exp=%h", s, obs, exp_v); end
      checks++;
      if (standby !== (s == 0) || b_gnt !== (s == 1 + WAKE))
        begin errors++; $display("FAIL wake_timing s=%0d got stby=%b gnt=%b", s, standby, b_gnt); end
      if (s == 2 + WAKE) begin
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 16'hBEEF)
          begin errors++; $display("FAIL wake_data got=%b %h exp=1 beef", b_rvalid, b_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_reset_in_flight();
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010; b_req = 1'b0;
    sample_step(); checks++;
    if (obs !== exp_v || a_gnt !== 1'b1) begin errors++; $display("FAIL rif_gnt got=%h exp=%h", obs, exp_v); end
    advance();
    rst = 1'b1;
    @(negedge clk);
    obs = {a_gnt, b_gnt, a_rvalid, b_rvalid, standby, a_rdata, b_rdata};
    checks++;
    if (obs !== 37'd0) begin errors++; $display("FAIL rif_discard got=%h exp=%h", obs, 37'd0); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0020;
    for (int i = 0; i < 3; i++) begin
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rif_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 0) begin
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || a_rvalid !== 1'b0)
          begin errors++; $display("FAIL rif_a_first got=%b%b%b exp=100", a_gnt, b_gnt, a_rvalid); end
      end
      advance();
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_withdraw();
    b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0021; b_wdata = 16'h5A5A; b_mask = 4'hF;
    a_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL wd_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i >= 1) begin
        checks++;
        if (b_gnt !== 1'b0 || b_rvalid !== 1'b0)
          begin errors++; $display("FAIL wd_no_b cyc=%0d got gnt=%b rv=%b exp 0 0", i, b_gnt, b_rvalid); end
      end
      advance();
      if (i == 0) begin
        b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0010;
      end else begin
        b_req = 1'b0;
      end
      if (i < 5) begin
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'(14'h0022 + i); a_wdata = 16'(i * 3 + 1); a_mask = 4'hF;
      end else begin
        a_req = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    for (int ad = 0; ad < 32; ad++) begin
      a_req = 1'b1; a_we = 1'b1; a_addr = 14'(ad); a_wdata = 16'($urandom); a_mask = 4'hF;
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rnd_init ad=%0d got=%h exp=%h", ad, obs, exp_v); end
      advance();
    end
    a_req = 1'b0; b_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit quiet;
      quiet = (c % 100) >= 80;
      if (!quiet) begin
        if (!a_req && $urandom_range(0, 1) == 1) begin
          a_req = 1'b1; a_we = 1'($urandom_range(0, 1)); a_addr = 14'($urandom_range(0, 31));
          a_wdata = 16'($urandom); a_mask = 4'($urandom);
        end else if (a_req && $urandom_range(0, 15) == 0) begin
          a_req = 1'b0;
        end
        if (!b_req && $urandom_range(0, 1) == 1) begin
          b_req = 1'b1; b_we = 1'($urandom_range(0, 1)); b_addr = 14'($urandom_range(0, 31));
          b_wdata = 16'($urandom); b_mask = 4'($urandom);
        end else if (b_req && $urandom_range(0, 15) == 0) begin
          b_req = 1'b0;
        end
      end
      sample_step(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rnd cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      advance();
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_contention();
    test_mask_top();
    test_standby_wake();
    test_reset_in_flight();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
